wishbone_rr_arbiter: RTL and testbench
======================================

Name: wishbone_rr_arbiter

Overview:
- N-master to 1-slave Wishbone classic arbiter, parametrised in master count and bus widths.
- Round-robin fairness; a grant is held for the owner's whole cyc.
- Adds a per-transfer ack timeout that returns err to the stalled master and frees the bus.
- Sits between CPU instruction/data ports (and later DMA) and the shared memory/peripheral slave.

Parameters:
- NUM_MASTERS, 2, number of master ports (>=2)
- ADR_WIDTH, 8, address width
- DAT_WIDTH, 8, data width
- SEL_WIDTH, 1, byte-select width (DAT_WIDTH/8)
- TIMEOUT_CYCLES, 16, stb-without-ack cycles before err (>=2)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- m_adr  input  NUM_MASTERS*ADR_WIDTH  master addresses, master i at slice i
- m_datwr  input  NUM_MASTERS*DAT_WIDTH  master write data
- m_datrd  output  DAT_WIDTH  read data, broadcast to all masters
- m_we  input  NUM_MASTERS  master write enables
- m_stb  input  NUM_MASTERS  master strobes
- m_cyc  input  NUM_MASTERS  master cycle/requests
- m_sel  input  NUM_MASTERS*SEL_WIDTH  master byte selects
- m_ack  output  NUM_MASTERS  per-master ack
- m_err  output  NUM_MASTERS  per-master timeout error
- s_adr  output  ADR_WIDTH  slave address
- s_datwr  output  DAT_WIDTH  slave write data
- s_datrd  input  DAT_WIDTH  slave read data
- s_we  output  1  slave write enable
- s_stb  output  1  slave strobe
- s_cyc  output  1  slave cycle
- s_sel  output  SEL_WIDTH  slave byte select
- s_ack  input  1  slave ack
- grant  output  NUM_MASTERS  one-hot current owner (debug/perf)

Behaviour:
- Reset (clk edge with rst=1): state IDLE, grant=0, last_owner=NUM_MASTERS-1 (master 0 highest priority first), timeout counter=0, m_err=0; consequently s_cyc=s_stb=0 and m_ack=0.
- Reset mid-transfer: s_cyc/s_stb fall the cycle after the reset edge; no ack/err issued afterwards.
- States: IDLE, OWNED, ERR.
- IDLE: if any m_cyc high, pick the first requester scanning last_owner+1 upward with wrap → register grant, last_owner=winner, go OWNED. Grant latency is 1 cycle from cyc to s_cyc.
- OWNED, combinational mux from owner k:
  - s_cyc=m_cyc[k], s_stb=m_stb[k]&m_cyc[k].
  - s_adr, s_datwr, s_we, s_sel driven from master k.
  - m_ack[k]=s_ack&s_stb; all other m_ack are 0.
- m_datrd=s_datrd at all times.
- OWNED with m_cyc[k]=0 at a clk edge: re-arbitrate in the same edge, excluding k unless it is the only requester. Next owner is granted the following cycle (back-to-back handoff, zero idle cycles). If there are no requesters, go IDLE with grant=0.
- Non-owners are never acked; they stall with cyc high.
- Timeout counter:
  - Increments each cycle s_stb=1 and s_ack=0.
  - Clears on s_ack, when s_stb=0, and on grant change.
  - On the edge where the counter reaches TIMEOUT_CYCLES-1 with still no ack: go ERR, m_err[k]=1 registered (one-cycle pulse next cycle), s_cyc/s_stb forced 0 from the next cycle.
- s_ack arriving on the same cycle as the timeout edge wins: ack delivered, no err.
- ERR: slave outputs idle. Wait for m_cyc[k]=0, then re-arbitrate as in OWNED release. A late s_ack in ERR is dropped.
- m_err is never asserted together with m_ack.
- Counter width: $clog2(TIMEOUT_CYCLES+1).

Decomposition:
- wishbone_pkg gains: typedef enum arb_state_t {ARB_IDLE, ARB_OWNED, ARB_ERR}; a localparam/function for counter width.
- Sub-module wishbone_rr_pick: combinational round-robin picker (req vector, last_owner index → one-hot winner, valid). Instantiated once; reusable by future interconnect.
- Arbiter top holds the FSM, grant register, timeout counter and datapath mux.

Test Plan:
- Single master: m_cyc[0]=m_stb[0]=1, adr=0x12, we=1, datwr=0xA5 → s_cyc=1 one cycle later, s_adr=0x12, s_datwr=0xA5; s_ack pulse → m_ack[0]=1 that cycle, m_ack[1]=0.
- Contention after reset: both masters raise cyc on the same cycle → grant=01 first. Master 0 drops cyc → grant=10 on the next cycle with no idle cycle. Master 0 re-requests → it is granted only after master 1 releases.
- Fairness: both masters hold requests, each doing one cycle then dropping cyc for 1 cycle → grants alternate 01,10,01,10 over 8 transactions.
- Timeout: master 1 owns the bus, slave never acks, TIMEOUT_CYCLES=16 → m_err[1] pulses once 16 cycles after s_stb rose, s_cyc=0 next cycle; bus stays in ERR until m_cyc[1] drops, then master 0 (pending) is granted.
- Ack at boundary: s_ack asserted exactly on the 16th stalled cycle → m_ack=1, m_err=0, state stays OWNED.
- Reset mid-transfer: rst=1 while master 0 owns with stb high → next cycle s_cyc=0, grant=0, m_ack=m_err=0. After rst=0 with both requesting → master 0 granted.

Source files
------------

// File: rtl/wishbone_pkg.sv
// Shared Wishbone interconnect types: arbiter state encoding and the
// width helper for the per-transfer ack-timeout counter.
package wishbone_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWNED = 2'd1,
    ARB_ERR   = 2'd2
  } arb_state_t;

  // Counter must be able to hold TIMEOUT_CYCLES itself, hence the +1.
  function automatic int unsigned tmo_cnt_width(input int unsigned timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/wishbone_rr_pick.sv
// Combinational round-robin picker: returns the first requester found when
// scanning upward from last_idx+1 with wrap, so last_idx itself comes last.
module wishbone_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0]   win_idx,
  output logic               valid
);

  // Scan all candidates in rotating priority order; first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path through
    // this block leaves a value unassigned, which would infer a latch.
    win_onehot = '0;
    win_idx    = '0;
    valid      = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int cand;
      cand = int'(last_idx) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!valid && req[cand]) begin
        valid            = 1'b1;
        win_onehot[cand] = 1'b1;
        win_idx          = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/wishbone_rr_arbiter.sv
// N-master to 1-slave Wishbone classic arbiter with round-robin fairness,
// grant held for the owner's whole cycle, and an ack timeout that returns
// err to a stalled master and frees the bus.
module wishbone_rr_arbiter
  import wishbone_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADR_WIDTH      = 8,
  parameter int DAT_WIDTH      = 8,
  parameter int SEL_WIDTH      = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_MASTERS*ADR_WIDTH-1:0] m_adr,
  input  logic [NUM_MASTERS*DAT_WIDTH-1:0] m_datwr,
  output logic [DAT_WIDTH-1:0]             m_datrd,
  input  logic [NUM_MASTERS-1:0]           m_we,
  input  logic [NUM_MASTERS-1:0]           m_stb,
  input  logic [NUM_MASTERS-1:0]           m_cyc,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0] m_sel,
  output logic [NUM_MASTERS-1:0]           m_ack,
  output logic [NUM_MASTERS-1:0]           m_err,
  output logic [ADR_WIDTH-1:0]             s_adr,
  output logic [DAT_WIDTH-1:0]             s_datwr,
  input  logic [DAT_WIDTH-1:0]             s_datrd,
  output logic                             s_we,
  output logic                             s_stb,
  output logic                             s_cyc,
  output logic [SEL_WIDTH-1:0]             s_sel,
  input  logic                             s_ack,
  output logic [NUM_MASTERS-1:0]           grant
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] m_err_q, m_err_d;
  logic [IDX_W-1:0]       last_owner_q, last_owner_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;

  logic own_cyc;
  logic own_stb;
  logic owned;

  // In OWNED/ERR last_owner_q is the current owner, so scanning from it
  // naturally places the releasing master last in the rotation.
  wishbone_rr_pick #(
    .NUM_REQ (NUM_MASTERS),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (m_cyc),
    .last_idx   (last_owner_q),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .valid      (pick_valid)
  );

  assign owned   = (state_q == ARB_OWNED);
  assign grant   = grant_q;
  assign m_err   = m_err_q;
  assign m_datrd = s_datrd;

  // Datapath mux from the owner; slave side is idle outside OWNED.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    s_adr   = '0;
    s_datwr = '0;
    s_we    = 1'b0;
    s_sel   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (last_owner_q == IDX_W'(i)) begin
        own_cyc = m_cyc[i];
        own_stb = m_stb[i];
        if (owned) begin
          s_adr   = m_adr[i*ADR_WIDTH +: ADR_WIDTH];
          s_datwr = m_datwr[i*DAT_WIDTH +: DAT_WIDTH];
          s_we    = m_we[i];
          s_sel   = m_sel[i*SEL_WIDTH +: SEL_WIDTH];
        end
      end
    end
    s_cyc = owned & own_cyc;
    s_stb = owned & own_cyc & own_stb;
  end

  // Ack routes only to the owner; a late ack during ERR is dropped.
  always_comb begin
    m_ack = '0;
    if (owned) m_ack = grant_q & {NUM_MASTERS{s_ack & s_stb}};
  end

  // Arbitration FSM, grant register and timeout counter next-state.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    cnt_d        = '0;
    m_err_d      = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d      = ARB_OWNED;
          grant_d      = pick_onehot;
          last_owner_d = pick_idx;
        end
      end
      ARB_OWNED: begin
        if (!own_cyc) begin
          state_d      = pick_valid ? ARB_OWNED : ARB_IDLE;
          grant_d      = pick_valid ? pick_onehot : '0;
          last_owner_d = pick_valid ? pick_idx : last_owner_q;
        end else if (s_stb && !s_ack) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ARB_ERR;
            m_err_d = grant_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ARB_ERR: begin
        if (!own_cyc) begin
          state_d      = pick_valid ? ARB_OWNED : ARB_IDLE;
          grant_d      = pick_valid ? pick_onehot : '0;
          last_owner_d = pick_valid ? pick_idx : last_owner_q;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_owner_q <= IDX_W'(NUM_MASTERS - 1);
      cnt_q        <= '0;
      m_err_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      m_err_q      <= m_err_d;
    end
  end

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Self-checking bench for wishbone_rr_arbiter (2 masters, 8-bit buses,
// TIMEOUT_CYCLES=16). Inputs change on the falling edge; outputs are
// sampled on the falling edge or shortly after an input change.
module tb_wishbone_rr_arbiter;

  localparam int NM = 2;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int SW = 1;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_datwr;
  logic [DW-1:0]  m_datrd;
  logic [NM-1:0]  m_we, m_stb, m_cyc, m_ack, m_err, grant;
  logic [NM*SW-1:0] m_sel;
  logic [AW-1:0]  s_adr;
  logic [DW-1:0]  s_datwr, s_datrd;
  logic           s_we, s_stb, s_cyc, s_ack;
  logic [SW-1:0]  s_sel;

  always #5 clk = ~clk;

  wishbone_rr_arbiter #(
    .NUM_MASTERS    (NM),
    .ADR_WIDTH      (AW),
    .DAT_WIDTH      (DW),
    .SEL_WIDTH      (SW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_adr   (m_adr),
    .m_datwr (m_datwr),
    .m_datrd (m_datrd),
    .m_we    (m_we),
    .m_stb   (m_stb),
    .m_cyc   (m_cyc),
    .m_sel   (m_sel),
    .m_ack   (m_ack),
    .m_err   (m_err),
    .s_adr   (s_adr),
    .s_datwr (s_datwr),
    .s_datrd (s_datrd),
    .s_we    (s_we),
    .s_stb   (s_stb),
    .s_cyc   (s_cyc),
    .s_sel   (s_sel),
    .s_ack   (s_ack),
    .grant   (grant)
  );

  int          n_run  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  // Packed bus status: {grant, s_cyc, s_stb, m_ack, m_err}.
  function automatic logic [31:0] mk(input logic [1:0] g, input logic c, input logic s,
                                     input logic [1:0] a, input logic [1:0] er);
    return {24'b0, g, c, s, a, er};
  endfunction

  function automatic logic [31:0] obs();
    return {24'b0, grant, s_cyc, s_stb, m_ack, m_err};
  endfunction

  task automatic drive_idle();
    m_cyc   = '0;
    m_stb   = '0;
    m_we    = '0;
    m_sel   = '0;
    m_adr   = '0;
    m_datwr = '0;
    s_ack   = 1'b0;
    s_datrd = '0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    exp_q.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 2'b00));
    @(negedge clk);
    @(negedge clk);
    e = exp_q.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL reset_state: got %h want %h", obs(), e); end
    m_cyc = 2'b11; m_stb = 2'b11;
    exp_q.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 2'b00));
    @(negedge clk);
    e = exp_q.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL reset_holds: got %h want %h", obs(), e); end
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_single();
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01; m_sel = 2'b01;
    m_adr = {8'h00, 8'h12}; m_datwr = {8'h00, 8'hA5};
    #1;
    exp_q.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 2'b00));
    e = exp_q.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL single_latency: got %h want %h", obs(), e); end
    exp_q.push_back(mk(2'b01, 1'b1, 1'b1, 2'b00, 2'b00));
    exp_q.push_back(32'h0003_12A5);
    @(negedge clk);
    e = exp_q.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL single_grant: got %h want %h", obs(), e); end
    e = exp_q.pop_front(); n_run++;
    if ({14'b0, s_we, s_sel, s_adr, s_datwr} !== e)
      begin n_fail++; $display("FAIL single_data: got %h want %h", {14'b0, s_we, s_sel, s_adr, s_datwr}, e); end
    s_ack = 1'b1; s_datrd = 8'h3C;
    exp_q.push_back(mk(2'b01, 1'b1, 1'b1, 2'b01, 2'b00));
    exp_q.push_back(32'h3C);
    #1;
    e = exp_q.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL single_ack: got %h want %h", obs(), e); end
    e = exp_q.pop_front(); n_run++;
    if ({24'b0, m_datrd} !== e) begin n_fail++; $display("FAIL single_datrd: got %h want %h", m_datrd, e); end
    @(negedge clk);
    s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
    exp_q.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 2'b00));
    @(negedge clk);
    e = exp_q.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL single_release: got %h want %h", obs(), e); end
    drive_idle();
  endtask

  task automatic test_contention();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b11; m_adr = {8'h31, 8'h20};
    exp_q.push_back(mk(2'b01, 1'b1, 1'b1, 2'b00, 2'b00));
    exp_q.push_back(32'h20);
    @(negedge clk);
    e = exp_q.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL contention_first: got %h want %h", obs(), e); end
    e = exp_q.pop_front(); n_run++;
    if ({24'b0, s_adr} !== e) begin n_fail++; $display("FAIL contention_adr0: got %h want %h", s_adr, e); end
    m_cyc = 2'b10; m_stb = 2'b10;
    exp_q.push_back(mk(2'b10, 1'b1, 1'b1, 2'b00, 2'b00));
    exp_q.push_back(32'h31);
    @(negedge clk);
    e = exp_q.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL contention_handoff: got %h want %h", obs(), e); end
    e = exp_q.pop_front(); n_run++;
    if ({24'b0, s_adr} !== e) begin n_fail++; $display("FAIL contention_adr1: got %h want %h", s_adr, e); end
    m_cyc = 2'b11; m_stb = 2'b11;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(2'b10, 1'b1, 1'b1, 2'b00, 2'b00));
      @(negedge clk);
      e = exp_q.pop_front(); n_run++;
      if (obs() !== e) begin n_fail++; $display("FAIL contention_hold%0d: got %h want %h", i, obs(), e); end
    end
    m_cyc = 2'b01; m_stb = 2'b01;
    exp_q.push_back(mk(2'b01, 1'b1, 1'b1, 2'b00, 2'b00));
    @(negedge clk);
    e = exp_q.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL contention_rerequest: got %h want %h", obs(), e); end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b11;
    for (int t = 0; t < 8; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_q.push_back({30'b0, exp_g});
      exp_q.push_back({30'b0, exp_g});
      @(negedge clk);
      e = exp_q.pop_front(); n_run++;
      if ({30'b0, grant} !== e) begin n_fail++; $display("FAIL fair_grant%0d: got %h want %h", t, grant, e); end
      s_ack = 1'b1;
      #1;
      e = exp_q.pop_front(); n_run++;
      if ({30'b0, m_ack} !== e) begin n_fail++; $display("FAIL fair_ack%0d: got %h want %h", t, m_ack, e); end
      #1;
      s_ack = 1'b0;
      m_cyc = ~exp_g; m_stb = ~exp_g;
    end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int  k;
    logic ack_seen;
    m_cyc = 2'b10; m_stb = 2'b10; m_adr = {8'h44, 8'h55};
    exp_q.push_back(mk(2'b10, 1'b1, 1'b1, 2'b00, 2'b00));
    @(negedge clk);
    e = exp_q.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL timeout_own: got %h want %h", obs(), e); end
    m_cyc = 2'b11; m_stb = 2'b11;
    exp_q.push_back(32'(TO));
    exp_q.push_back(32'h0);
    k = 0; ack_seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (m_ack !== 2'b00) ack_seen = 1'b1;
      if (m_err !== 2'b00) begin k = i; break; end
    end
    e = exp_q.pop_front(); n_run++;
    if (32'(k) !== e) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d (0 = no err within bound)", k, e); end
    e = exp_q.pop_front(); n_run++;
    if ({31'b0, ack_seen} !== e) begin n_fail++; $display("FAIL timeout_stray_ack: got %h want %h", ack_seen, e); end
    exp_q.push_back(mk(2'b10, 1'b0, 1'b0, 2'b00, 2'b10));
    e = exp_q.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL timeout_err_pulse: got %h want %h", obs(), e); end
    @(negedge clk);
    s_ack = 1'b1;
    #1;
    exp_q.push_back(mk(2'b10, 1'b0, 1'b0, 2'b00, 2'b00));
    e = exp_q.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL timeout_late_ack: got %h want %h", obs(), e); end
    s_ack = 1'b0;
    m_cyc = 2'b01; m_stb = 2'b01;
    exp_q.push_back(mk(2'b01, 1'b1, 1'b1, 2'b00, 2'b00));
    exp_q.push_back(32'h55);
    @(negedge clk);
    e = exp_q.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL timeout_handoff: got %h want %h", obs(), e); end
    e = exp_q.pop_front(); n_run++;
    if ({24'b0, s_adr} !== e) begin n_fail++; $display("FAIL timeout_handoff_adr: got %h want %h", s_adr, e); end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_ack_boundary();
    m_cyc = 2'b01; m_stb = 2'b01;
    @(negedge clk);
    repeat (TO - 1) @(negedge clk);
    s_ack = 1'b1;
    #1;
    exp_q.push_back(mk(2'b01, 1'b1, 1'b1, 2'b01, 2'b00));
    e = exp_q.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL boundary_ack: got %h want %h", obs(), e); end
    @(negedge clk);
    s_ack = 1'b0;
    #1;
    exp_q.push_back(mk(2'b01, 1'b1, 1'b1, 2'b00, 2'b00));
    e = exp_q.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL boundary_no_err: got %h want %h", obs(), e); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    @(negedge clk);
    s_ack = 1'b1;
    #1;
    exp_q.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 2'b00));
    e = exp_q.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL reset_mid_idle: got %h want %h", obs(), e); end
    s_ack = 1'b0;
    rst = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b11;
    exp_q.push_back(mk(2'b01, 1'b1, 1'b1, 2'b00, 2'b00));
    @(negedge clk);
    e = exp_q.pop_front(); n_run++;
    if (obs() !== e) begin n_fail++; $display("FAIL reset_mid_regrant: got %h want %h", obs(), e); end
    drive_idle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_timeout();
    test_ack_boundary();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
